pinball_game_ctrl: RTL and testbench
====================================

Name: pinball_game_ctrl

Overview:
- Parametrised top-level game-flow controller for the pinball game; successor to the single-life start/play controller.
- Adds the following on top of start/pause/play:
  - multiple lives;
  - level progression;
  - a game-over state;
  - a hit cooldown;
  - a selectable score-on-ball-loss mode.
- Sits between the collision detectors and the ball/obstacle drawing units.
- Drives pause, level-restart, score, lives and level to the display/HUD.

Parameters:
SCORE_W, 8, score register width
LIVES, 3, balls per game (>=1)
NUM_LEVELS, 4, number of levels (>=1)
LEVEL_SCORE, 10, hits per level needed to advance
HIT_COOLDOWN, 16, cycles after a counted hit during which further hits are ignored (>=1)
KEEP_SCORE_ON_LOSS, 1, 1 = score kept on ball loss; 0 = score cleared on ball loss

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start_key  in  1  level of start key (key5); rising edge is the start event
collision_bottom  in  1  ball hit bottom border (level, may persist several cycles)
collision_obstacle_real  in  1  qualified obstacle hit
pause  out  1  1 = freeze ball motion
reset_level  out  1  one-cycle pulse: respawn ball, redraw obstacles
level_up  out  1  one-cycle pulse on level advance
game_over  out  1  high in GAME_OVER state
score  out  SCORE_W  current score, saturating
lives  out  $clog2(LIVES+1)  remaining balls
level  out  $clog2(NUM_LEVELS) (min 1)  current level, 0-based

Behaviour:
- All state updates on posedge clk. Reset is synchronous: when reset is 1 at a clock edge, the following values load:
  - state=IDLE, score=0, lives=LIVES, level=0;
  - hit counter=0, cooldown=0;
  - start_key edge-detect register=start_key.
- Outputs are registered or decoded from registered state. Reset values: pause=1, reset_level=0, level_up=0, game_over=0.
- Start event = start_key & ~start_key_d (single cycle). A key held through reset does not start the game.
- States: IDLE, PLAY, LOST, LEVEL_UP, GAME_OVER.
  - IDLE: pause=1. On a start event -> PLAY.
  - PLAY: pause=0. Resolution per cycle, in priority order:
    1. collision_bottom=1: go to LOST; any hit in the same cycle is ignored.
    2. Otherwise, collision_obstacle_real=1 with cooldown=0 is a counted hit:
       - score += 1, saturating at 2^SCORE_W-1;
       - hit counter += 1;
       - cooldown loads HIT_COOLDOWN.
       - If the hit counter reaches LEVEL_SCORE and level<NUM_LEVELS-1: go to LEVEL_UP.
    3. Hits while cooldown!=0 are ignored.
    - Cooldown decrements every cycle while nonzero, in any state.
  - LOST: one cycle. reset_level=1, pause=1.
    - lives decrements.
    - If KEEP_SCORE_ON_LOSS=0, score is cleared.
    - If lives was 1 (it now becomes 0): go to GAME_OVER. Otherwise: go to IDLE.
  - LEVEL_UP: one cycle. level_up=1, reset_level=1, pause=1.
    - level += 1; hit counter cleared.
    - Go to IDLE; the player presses start again.
  - At the last level, reaching LEVEL_SCORE does not advance. The hit counter saturates at LEVEL_SCORE; score keeps counting.
  - GAME_OVER: pause=1, game_over=1. A start event reinitialises score, lives, level, hit counter and cooldown to reset values and goes to IDLE. It does not start play directly.
- reset_level and level_up are exactly one cycle wide per event.
- A collision_bottom level persisting into IDLE is ignored.
- Reset asserted mid-game (any state) takes precedence over every event in that cycle.

Decomposition:
- Package pinball_pkg:
  - state enum game_state_t {IDLE, PLAY, LOST, LEVEL_UP, GAME_OVER};
  - shared constants for default LIVES/NUM_LEVELS, reused by the HUD.
- One natural sub-module: pinball_edge_detect, a rising-edge pulse generator with synchronous active-high reset, used for start_key.
- Score/lives/level counters stay inline.

Test Plan:
1. Reset, start_key held high across reset release -> remains IDLE, pause=1. Release then press -> PLAY the next cycle, pause=0.
2. In PLAY, pulse collision_obstacle_real on 3 consecutive cycles, HIT_COOLDOWN=16 -> score=1. Another hit 16 cycles after the counted hit -> score=2.
3. In PLAY with score=5, assert collision_bottom and a hit in the same cycle:
   - KEEP_SCORE_ON_LOSS=1 -> score stays 5;
   - KEEP_SCORE_ON_LOSS=0 -> score=0;
   - in both cases, one reset_level pulse, lives 3->2, IDLE.
4. Lose 3 balls (LIVES=3) -> third loss ends in GAME_OVER, game_over=1, lives=0. Start event -> IDLE, score=0, lives=3, level=0.
5. LEVEL_SCORE=10: 10 counted hits -> level_up and reset_level pulse together for 1 cycle, level=1, IDLE.
6. At level NUM_LEVELS-1, 10 more hits -> no level_up, score continues. SCORE_W=4, 20 hits -> score saturates at 15.

Source files
------------

// File: rtl/pinball_pkg.sv
// Shared types and defaults for the pinball game-flow controller and HUD.
package pinball_pkg;

   typedef enum logic [2:0] {IDLE, PLAY, LOST, LEVEL_UP, GAME_OVER} game_state_t;

   localparam int DEFAULT_LIVES      = 3;
   localparam int DEFAULT_NUM_LEVELS = 4;

   // Level index width, never narrower than one bit.
   function automatic int level_w(input int num_levels);
      return (num_levels > 1) ? $clog2(num_levels) : 1;
   endfunction

endpackage

// File: rtl/pinball_edge_detect.sv
// Rising-edge pulse generator; reset loads the current input level so a held key yields no pulse.
module pinball_edge_detect (
   input  logic clk,
   input  logic reset,
   input  logic sig,
   output logic pulse
);

   logic sig_d;

   always_ff @(posedge clk) begin
      if (reset) sig_d <= sig;
      else       sig_d <= sig;
   end

   assign pulse = sig & ~sig_d;

endmodule

// File: rtl/pinball_game_ctrl.sv
// Pinball game-flow controller: start/pause/play with lives, levels, hit cooldown and game over.
module pinball_game_ctrl
   import pinball_pkg::*;
#(
   parameter int SCORE_W            = 8,
   parameter int LIVES              = DEFAULT_LIVES,
   parameter int NUM_LEVELS         = DEFAULT_NUM_LEVELS,
   parameter int LEVEL_SCORE        = 10,
   parameter int HIT_COOLDOWN       = 16,
   parameter int KEEP_SCORE_ON_LOSS = 1
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                start_key,
   input  logic                                collision_bottom,
   input  logic                                collision_obstacle_real,
   output logic                                pause,
   output logic                                reset_level,
   output logic                                level_up,
   output logic                                game_over,
   output logic [SCORE_W-1:0]                  score,
   output logic [$clog2(LIVES+1)-1:0]          lives,
   output logic [level_w(NUM_LEVELS)-1:0]      level
);

   localparam int LW  = $clog2(LIVES + 1);
   localparam int LVW = level_w(NUM_LEVELS);
   localparam int HW  = $clog2(LEVEL_SCORE + 1);
   localparam int CW  = $clog2(HIT_COOLDOWN + 1);

   game_state_t     state, state_nxt;
   logic            start_evt;
   logic            counted_hit;
   logic [HW-1:0]   hit_cnt, hit_cnt_nxt;
   logic [CW-1:0]   cooldown;

   pinball_edge_detect u_start_edge (
      .clk   (clk),
      .reset (reset),
      .sig   (start_key),
      .pulse (start_evt)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Hit counter holds at LEVEL_SCORE on the last level while score keeps counting.
   assign hit_cnt_nxt = (hit_cnt == HW'(LEVEL_SCORE)) ? hit_cnt : hit_cnt + 1'b1;

   always_comb begin
      state_nxt   = state;
      pause       = 1'b1;
      reset_level = 1'b0;
      level_up    = 1'b0;
      game_over   = 1'b0;
      counted_hit = 1'b0;
      case (state)
         IDLE: begin
            if (start_evt) state_nxt = PLAY;
         end
         PLAY: begin
            pause = 1'b0;
            if (collision_bottom) begin
               state_nxt = LOST;
            end else if (collision_obstacle_real && cooldown == '0) begin
               counted_hit = 1'b1;
               if (hit_cnt_nxt == HW'(LEVEL_SCORE) && level != LVW'(NUM_LEVELS - 1))
                  state_nxt = LEVEL_UP;
            end
         end
         LOST: begin
            reset_level = 1'b1;
            state_nxt   = (lives == LW'(1)) ? GAME_OVER : IDLE;
         end
         LEVEL_UP: begin
            level_up    = 1'b1;
            reset_level = 1'b1;
            state_nxt   = IDLE;
         end
         GAME_OVER: begin
            game_over = 1'b1;
            if (start_evt) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         score    <= '0;
         lives    <= LW'(LIVES);
         level    <= '0;
         hit_cnt  <= '0;
         cooldown <= '0;
      end else begin
         if (cooldown != '0) cooldown <= cooldown - 1'b1;
         case (state)
            PLAY: begin
               if (counted_hit) begin
                  if (score != '1) score <= score + 1'b1;
                  hit_cnt  <= hit_cnt_nxt;
                  cooldown <= CW'(HIT_COOLDOWN);
               end
            end
            LOST: begin
               lives <= lives - 1'b1;
               if (KEEP_SCORE_ON_LOSS == 0) score <= '0;
            end
            LEVEL_UP: begin
               level   <= level + 1'b1;
               hit_cnt <= '0;
            end
            GAME_OVER: begin
               if (start_evt) begin
                  score    <= '0;
                  lives    <= LW'(LIVES);
                  level    <= '0;
                  hit_cnt  <= '0;
                  cooldown <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pinball_game_ctrl.sv
// Directed bench for pinball_game_ctrl: default configuration plus a small single-level variant.
module tb_pinball_game_ctrl;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic       a_start, a_bot, a_hit;
   logic       a_pause, a_rl, a_lu, a_go;
   logic [7:0] a_score;
   logic [1:0] a_lives;
   logic [1:0] a_level;

   logic       b_start, b_bot, b_hit;
   logic       b_pause, b_rl, b_lu, b_go;
   logic [3:0] b_score;
   logic [1:0] b_lives;
   logic [0:0] b_level;

   int checks   = 0;
   int failures = 0;

   pinball_game_ctrl #(
      .SCORE_W(8), .LIVES(3), .NUM_LEVELS(4), .LEVEL_SCORE(10),
      .HIT_COOLDOWN(16), .KEEP_SCORE_ON_LOSS(1)
   ) dut_a (
      .clk(clk), .reset(reset), .start_key(a_start),
      .collision_bottom(a_bot), .collision_obstacle_real(a_hit),
      .pause(a_pause), .reset_level(a_rl), .level_up(a_lu), .game_over(a_go),
      .score(a_score), .lives(a_lives), .level(a_level)
   );

   pinball_game_ctrl #(
      .SCORE_W(4), .LIVES(2), .NUM_LEVELS(1), .LEVEL_SCORE(3),
      .HIT_COOLDOWN(1), .KEEP_SCORE_ON_LOSS(0)
   ) dut_b (
      .clk(clk), .reset(reset), .start_key(b_start),
      .collision_bottom(b_bot), .collision_obstacle_real(b_hit),
      .pause(b_pause), .reset_level(b_rl), .level_up(b_lu), .game_over(b_go),
      .score(b_score), .lives(b_lives), .level(b_level)
   );

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic press_a();
      a_start = 1'b0; step(1);
      a_start = 1'b1; step(1);
      a_start = 1'b0;
   endtask

   task automatic press_b();
      b_start = 1'b0; step(1);
      b_start = 1'b1; step(1);
      b_start = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      a_start = 1'b1; a_bot = 1'b0; a_hit = 1'b0;
      b_start = 1'b0; b_bot = 1'b0; b_hit = 1'b0;
      step(2);
      reset = 1'b0;
      chk("rst_pause",  32'(a_pause), 1);
      chk("rst_rl",     32'(a_rl),    0);
      chk("rst_lu",     32'(a_lu),    0);
      chk("rst_go",     32'(a_go),    0);
      chk("rst_score",  32'(a_score), 0);
      chk("rst_lives",  32'(a_lives), 3);
      chk("rst_level",  32'(a_level), 0);

      // key held across reset release must not start
      step(3);
      chk("held_key_idle", 32'(a_pause), 1);
      press_a();
      chk("start_play", 32'(a_pause), 0);

      // three back-to-back hits: only the first counts
      a_hit = 1'b1; step(1);
      chk("hit1", 32'(a_score), 1);
      step(2);
      a_hit = 1'b0;
      chk("cooldown_ignore", 32'(a_score), 1);
      step(14);
      a_hit = 1'b1; step(1); a_hit = 1'b0;
      chk("hit_after_cd", 32'(a_score), 2);
      repeat (3) begin
         step(16);
         a_hit = 1'b1; step(1); a_hit = 1'b0;
      end
      chk("score5", 32'(a_score), 5);

      // bottom and hit together: bottom wins
      step(16);
      a_bot = 1'b1; a_hit = 1'b1; step(1); a_hit = 1'b0;
      chk("lost_rl",    32'(a_rl),    1);
      chk("lost_pause", 32'(a_pause), 1);
      chk("lost_score", 32'(a_score), 5);
      step(1);
      chk("lost_idle_rl", 32'(a_rl),    0);
      chk("lost_lives",   32'(a_lives), 2);
      chk("lost_keep",    32'(a_score), 5);
      step(1);
      a_bot = 1'b0;
      chk("bot_in_idle", 32'(a_pause), 1);
      chk("bot_in_idle_lives", 32'(a_lives), 2);

      press_a();
      a_bot = 1'b1; step(1); a_bot = 1'b0; step(1);
      chk("lives1", 32'(a_lives), 1);
      chk("lives1_go", 32'(a_go), 0);
      press_a();
      a_bot = 1'b1; step(1); a_bot = 1'b0; step(1);
      chk("go_flag",  32'(a_go),    1);
      chk("go_lives", 32'(a_lives), 0);
      chk("go_pause", 32'(a_pause), 1);
      step(1);
      chk("go_stays", 32'(a_go), 1);
      press_a();
      chk("restart_go",    32'(a_go),    0);
      chk("restart_score", 32'(a_score), 0);
      chk("restart_lives", 32'(a_lives), 3);
      chk("restart_level", 32'(a_level), 0);
      chk("restart_idle",  32'(a_pause), 1);

      // ten counted hits advance the level
      press_a();
      chk("play_again", 32'(a_pause), 0);
      repeat (9) begin
         a_hit = 1'b1; step(1); a_hit = 1'b0;
         step(16);
      end
      chk("nine_hits_play", 32'(a_pause), 0);
      chk("nine_hits_lu",   32'(a_lu),    0);
      a_hit = 1'b1; step(1); a_hit = 1'b0;
      chk("lu_pulse", 32'(a_lu),    1);
      chk("lu_rl",    32'(a_rl),    1);
      chk("lu_pause", 32'(a_pause), 1);
      chk("lu_score", 32'(a_score), 10);
      step(1);
      chk("lu_once",     32'(a_lu),    0);
      chk("lu_rl_once",  32'(a_rl),    0);
      chk("lu_level",    32'(a_level), 1);
      chk("lu_idle",     32'(a_pause), 1);

      // single-level variant: no advance, score saturates at 15
      press_b();
      chk("b_play", 32'(b_pause), 0);
      repeat (3) begin
         b_hit = 1'b1; step(1); b_hit = 1'b0; step(1);
      end
      chk("b_score3",    32'(b_score), 3);
      chk("b_no_lu",     32'(b_pause), 0);
      repeat (17) begin
         b_hit = 1'b1; step(1);
         chk("b_lu_never", 32'(b_lu), 0);
         b_hit = 1'b0; step(1);
      end
      chk("b_sat",   32'(b_score), 15);
      chk("b_level", 32'(b_level), 0);
      b_bot = 1'b1; b_hit = 1'b1; step(1); b_bot = 1'b0; b_hit = 1'b0;
      chk("b_lost_rl", 32'(b_rl), 1);
      step(1);
      chk("b_clear", 32'(b_score), 0);
      chk("b_lives", 32'(b_lives), 1);
      press_b();
      b_bot = 1'b1; step(1); b_bot = 1'b0; step(1);
      chk("b_go",       32'(b_go),    1);
      chk("b_go_lives", 32'(b_lives), 0);

      // reset mid-game overrides a start press
      reset = 1'b1; b_start = 1'b1; step(1);
      chk("mid_rst_go",    32'(b_go),    0);
      chk("mid_rst_lives", 32'(b_lives), 2);
      chk("mid_rst_pause", 32'(b_pause), 1);
      chk("mid_rst_alvl",  32'(a_level), 0);
      reset = 1'b0; step(2);
      chk("mid_rst_held", 32'(b_pause), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
